// File: rtl/bit_stuff_encoder_if.sv
// Serial bit-source and line-output bundle for the USB bit-stuffing encoder.
// The slave side is the encoder. The master side drives the bit sources and watches the line.
interface bit_stuff_encoder_if #(
   parameter int NUM_SRC = 2
);
   logic [NUM_SRC-1:0] src_valid;
   logic [NUM_SRC-1:0] src_bit;
   logic [NUM_SRC-1:0] src_ready;
   logic               out_valid;
   logic               out_bit;

   modport master (
      output src_valid, src_bit,
      input  src_ready, out_valid, out_bit
   );

   modport slave (
      input  src_valid, src_bit,
      output src_ready, out_valid, out_bit
   );
endinterface

// File: rtl/bit_stuff_encoder.sv
// USB transmit bit-stuffing encoder: locks onto one of NUM_SRC serial sources per packet,
// passes the PID through and inserts a 0 after every RUN_LEN consecutive ones.
module bit_stuff_encoder #(
   parameter int RUN_LEN  = 6,
   parameter int SKIP_LEN = 8,
   parameter int NUM_SRC  = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   bit_stuff_encoder_if.slave  bus,
   input  logic                stuff_en,
   input  logic                stat_clr,
   output logic                busy,
   output logic [15:0]         stuff_cnt
);
   localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int SKIP_W = (SKIP_LEN > 0) ? $clog2(SKIP_LEN + 1) : 1;
   localparam int ONES_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

   typedef enum logic [1:0] {IDLE, SKIP, RUN, STUFF} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d, first_idx;
   logic [SKIP_W-1:0]   skip_q, skip_d;
   logic [ONES_W-1:0]   ones_q, ones_d, ones_base;
   logic [15:0]         cnt_q, cnt_d;
   logic [NUM_SRC-1:0]  ready;
   logic                valid_o, bit_o, busy_c, run_act, run_bit;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      skip_d    = skip_q;
      ones_d    = ones_q;
      ready     = '0;
      valid_o   = 1'b0;
      bit_o     = 1'b0;
      busy_c    = (state_q != IDLE);
      run_act   = 1'b0;
      run_bit   = 1'b0;
      first_idx = '0;
      ones_base = (state_q == IDLE) ? '0 : ones_q;

      // Descending scan so the lowest-index valid source wins arbitration
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (bus.src_valid[i]) first_idx = SEL_W'(i);
      end

      case (state_q)
         IDLE: begin
            if (|bus.src_valid) begin
               ready[first_idx] = 1'b1;
               valid_o          = 1'b1;
               bit_o            = bus.src_bit[first_idx];
               busy_c           = 1'b1;
               sel_d            = first_idx;
               ones_d           = '0;
               if (SKIP_LEN == 0) begin
                  run_act = 1'b1;
                  run_bit = bus.src_bit[first_idx];
                  state_d = RUN;
               end else begin
                  skip_d  = SKIP_W'(1);
                  state_d = (SKIP_LEN > 1) ? SKIP : RUN;
               end
            end
         end
         SKIP: begin
            if (bus.src_valid[sel_q]) begin
               ready[sel_q] = 1'b1;
               valid_o      = 1'b1;
               bit_o        = bus.src_bit[sel_q];
               skip_d       = skip_q + 1'b1;
               if (int'(skip_q) + 1 >= SKIP_LEN) state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.src_valid[sel_q]) begin
               ready[sel_q] = 1'b1;
               valid_o      = 1'b1;
               bit_o        = bus.src_bit[sel_q];
               run_act      = 1'b1;
               run_bit      = bus.src_bit[sel_q];
            end else begin
               state_d = IDLE;
               ones_d  = '0;
            end
         end
         STUFF: begin
            valid_o = 1'b1;
            bit_o   = 1'b0;
            state_d = bus.src_valid[sel_q] ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A completed run always clears the count; stuff_en only decides whether a 0 follows
      if (run_act) begin
         if (!run_bit) begin
            ones_d = '0;
         end else if (int'(ones_base) + 1 >= RUN_LEN) begin
            ones_d = '0;
            if (stuff_en) state_d = STUFF;
         end else begin
            ones_d = ones_base + 1'b1;
         end
      end

      if (!reset_n) begin
         valid_o = 1'b0;
         bit_o   = 1'b0;
         busy_c  = 1'b0;
      end

      if (stat_clr)                                 cnt_d = '0;
      else if (state_q == STUFF && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      else                                          cnt_d = cnt_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         skip_q  <= '0;
         ones_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         skip_q  <= skip_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.src_ready = ready;
   assign bus.out_valid = valid_o;
   assign bus.out_bit   = bit_o;
   assign busy          = busy_c;
   assign stuff_cnt     = cnt_q;
endmodule

// File: tb/tb_bit_stuff_encoder.sv
// Self-checking bench for bit_stuff_encoder: directed packets plus random single-source packets,
// compared cycle by cycle against a packet-level stuffing model.
module tb_bit_stuff_encoder;
   localparam int RUN_LEN  = 6;
   localparam int SKIP_LEN = 8;
   localparam int NUM_SRC  = 2;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        stuffEn = 1'b1;
   logic        statClr = 1'b0;
   logic        busy;
   logic [15:0] stuffCnt;

   bit_stuff_encoder_if #(.NUM_SRC(NUM_SRC)) ifc ();

   bit_stuff_encoder #(
      .RUN_LEN (RUN_LEN),
      .SKIP_LEN(SKIP_LEN),
      .NUM_SRC (NUM_SRC)
   ) dut (
      .clock    (clock),
      .reset_n  (resetN),
      .bus      (ifc),
      .stuff_en (stuffEn),
      .stat_clr (statClr),
      .busy     (busy),
      .stuff_cnt(stuffCnt)
   );

   always #5 clock = ~clock;

   int nChecks = 0;
   int nErrors = 0;
   int expQ[$];
   bit inPkt = 1'b0;
   int expCnt = 0;
   bit pkt0[$];
   bit pkt1[$];
   int start0 = 0;
   int start1 = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Packet-level model: every bit goes out, and after the PID a 0 follows each run of RUN_LEN ones
   function automatic int encode(input bit bits[$], input bit en, output bit outq[$]);
      int run = 0;
      int n = 0;
      outq.delete();
      foreach (bits[k]) begin
         outq.push_back(bits[k]);
         if (k >= SKIP_LEN) begin
            if (bits[k]) begin
               run++;
               if (run == RUN_LEN) begin
                  run = 0;
                  if (en) begin
                     outq.push_back(1'b0);
                     n++;
                  end
               end
            end else begin
               run = 0;
            end
         end
      end
      return n;
   endfunction

   function automatic bit [31:0] packQ(input bit q[$]);
      bit [31:0] v = '0;
      foreach (q[i]) v = {v[30:0], q[i]};
      return v;
   endfunction

   function automatic void fromVec(input bit [31:0] v, input int len, output bit q[$]);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(v[len-1-i]);
   endfunction

   task automatic pushExpected(input bit q[$]);
      foreach (q[i]) expQ.push_back(int'(q[i]));
      expQ.push_back(2);
   endtask

   task automatic addStuffs(input int n);
      expCnt = (expCnt + n > 65535) ? 65535 : expCnt + n;
   endtask

   // One cycle of line checking; a queue entry of 2 demands an out_valid=0 cycle between packets
   task automatic compareCycle();
      if (!resetN) return;
      checkOutput("ready_onehot0", 32'($onehot0(ifc.src_ready)), 32'd1);
      if (expQ.size() == 0) begin
         checkOutput("idle_out_valid", 32'(ifc.out_valid), 32'd0);
         inPkt = 1'b0;
      end else if (expQ[0] == 2) begin
         checkOutput("pkt_gap", 32'(ifc.out_valid), 32'd0);
         void'(expQ.pop_front());
         inPkt = 1'b0;
      end else if (ifc.out_valid) begin
         checkOutput("out_bit", 32'(ifc.out_bit), 32'(expQ[0]));
         void'(expQ.pop_front());
         inPkt = 1'b1;
      end else if (inPkt) begin
         checkOutput("pkt_contiguous", 32'(ifc.out_valid), 32'd1);
      end
   endtask

   task automatic applyStimulus(input bit en, input bit clrOnStuff, input int rstAtStuff,
                                input int maxCycles, output int stuffSeen);
      int cyc = 0;
      int idx0 = 0;
      int idx1 = 0;
      int tail = 0;
      bit v0, v1, acc0, acc1, isStuff;
      stuffSeen = 0;
      stuffEn = en;
      forever begin
         v0 = (cyc >= start0) && (idx0 < pkt0.size());
         v1 = (cyc >= start1) && (idx1 < pkt1.size());
         ifc.src_valid = {v1, v0};
         ifc.src_bit   = {v1 ? pkt1[idx1] : 1'b0, v0 ? pkt0[idx0] : 1'b0};
         if (idx0 >= pkt0.size() && idx1 >= pkt1.size()) tail++;
         if (tail > 3) break;
         if (cyc >= maxCycles) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL scenario_budget: got %0d cycles, expected completion within %0d", cyc, maxCycles);
            break;
         end
         @(negedge clock);
         compareCycle();
         acc0 = v0 && ifc.src_ready[0];
         acc1 = v1 && ifc.src_ready[1];
         isStuff = ifc.out_valid && (ifc.src_ready == '0) && busy;
         if (isStuff) begin
            stuffSeen++;
            if (clrOnStuff) statClr = 1'b1;
            if (stuffSeen == rstAtStuff) begin
               resetN = 1'b0;
               ifc.src_valid = '0;
               #1;
               checkOutput("rst_out_valid", 32'(ifc.out_valid), 32'd0);
               checkOutput("rst_busy", 32'(busy), 32'd0);
               checkOutput("rst_stuff_cnt", 32'(stuffCnt), 32'd0);
               idx0 = pkt0.size();
               idx1 = pkt1.size();
               acc0 = 1'b0;
               acc1 = 1'b0;
               expQ.delete();
               inPkt = 1'b0;
            end
         end
         @(posedge clock);
         #1;
         statClr = 1'b0;
         resetN  = 1'b1;
         if (acc0) idx0++;
         if (acc1) idx1++;
         cyc++;
      end
      ifc.src_valid = '0;
      ifc.src_bit   = '0;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      bit oq[$];
      int n, seen, s, len;
      bit en;

      ifc.src_valid = '0;
      ifc.src_bit   = '0;
      repeat (2) @(negedge clock);
      checkOutput("reset_out_valid", 32'(ifc.out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_stuff_cnt", 32'(stuffCnt), 32'd0);
      checkOutput("reset_src_ready", 32'(ifc.src_ready), 32'd0);
      @(posedge clock);
      #1;
      resetN = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      $display("[TB] PID skip packet");
      fromVec(32'h7FFF, 15, pkt0); pkt1.delete(); start0 = 0; start1 = 0;
      n = encode(pkt0, 1'b1, oq);
      checkOutput("pid_model_len", 32'(oq.size()), 32'd16);
      checkOutput("pid_model_bits", packQ(oq), 32'hFFFD);
      pushExpected(oq); addStuffs(n);
      applyStimulus(1'b1, 1'b0, 0, 200, seen);
      checkOutput("pid_stall_cycles", 32'(seen), 32'd1);
      checkOutput("pid_stuff_cnt", 32'(stuffCnt), 32'd1);

      $display("[TB] Tail stuff packet");
      fromVec(32'h003F, 14, pkt0);
      n = encode(pkt0, 1'b1, oq);
      checkOutput("tail_model_len", 32'(oq.size()), 32'd15);
      checkOutput("tail_model_bits", packQ(oq), 32'h007E);
      pushExpected(oq); addStuffs(n);
      applyStimulus(1'b1, 1'b0, 0, 200, seen);
      checkOutput("tail_stuff_cnt", 32'(stuffCnt), 32'd2);

      $display("[TB] Pass-through mode");
      fromVec(32'h00FFF, 20, pkt0);
      n = encode(pkt0, 1'b0, oq);
      checkOutput("mode_model_len", 32'(oq.size()), 32'd20);
      checkOutput("mode_model_bits", packQ(oq), 32'h00FFF);
      pushExpected(oq); addStuffs(n);
      applyStimulus(1'b0, 1'b0, 0, 200, seen);
      checkOutput("mode_stuff_cnt", 32'(stuffCnt), 32'd2);

      $display("[TB] Arbitration: src1 locked, src0 arrives late");
      fromVec(32'hA52, 12, pkt1); start1 = 0;
      fromVec(32'h3C4, 12, pkt0); start0 = 4;
      n = encode(pkt1, 1'b1, oq); pushExpected(oq); addStuffs(n);
      n = encode(pkt0, 1'b1, oq); pushExpected(oq); addStuffs(n);
      applyStimulus(1'b1, 1'b0, 0, 200, seen);

      $display("[TB] Arbitration: simultaneous start");
      fromVec(32'h5A1, 12, pkt0); start0 = 0;
      fromVec(32'h0F0, 12, pkt1); start1 = 0;
      n = encode(pkt0, 1'b1, oq); pushExpected(oq); addStuffs(n);
      n = encode(pkt1, 1'b1, oq); pushExpected(oq); addStuffs(n);
      applyStimulus(1'b1, 1'b0, 0, 200, seen);
      checkOutput("arb_stuff_cnt", 32'(stuffCnt), 32'(expCnt));

      $display("[TB] Random single-source packets");
      for (int p = 0; p < 25; p++) begin
         s   = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 30));
         en  = 1'($urandom_range(0, 1));
         pkt0.delete(); pkt1.delete(); start0 = 0; start1 = 0;
         for (int i = 0; i < len; i++) begin
            if (s == 0) pkt0.push_back($urandom_range(0, 3) != 0);
            else        pkt1.push_back($urandom_range(0, 3) != 0);
         end
         n = (s == 0) ? encode(pkt0, en, oq) : encode(pkt1, en, oq);
         pushExpected(oq); addStuffs(n);
         applyStimulus(en, 1'b0, 0, 200, seen);
         checkOutput("rand_stuff_count", 32'(seen), 32'(n));
         checkOutput("rand_stuff_cnt", 32'(stuffCnt), 32'(expCnt));
      end

      $display("[TB] Counter saturation");
      force dut.cnt_q = 16'hFFFE;
      @(posedge clock);
      #1;
      release dut.cnt_q;
      expCnt = 65534;
      fromVec(32'h1FFE, 21, pkt0); pkt1.delete(); start0 = 0; start1 = 0;
      n = encode(pkt0, 1'b1, oq);
      checkOutput("sat_model_stuffs", 32'(n), 32'd2);
      pushExpected(oq); addStuffs(n);
      applyStimulus(1'b1, 1'b0, 0, 200, seen);
      checkOutput("sat_stuff_cnt", 32'(stuffCnt), 32'hFFFF);

      $display("[TB] Clear colliding with a stuff");
      fromVec(32'h003F, 14, pkt0);
      n = encode(pkt0, 1'b1, oq);
      pushExpected(oq); expCnt = 0;
      applyStimulus(1'b1, 1'b1, 0, 200, seen);
      checkOutput("clr_stuff_cnt", 32'(stuffCnt), 32'd0);

      $display("[TB] Reset during stuff");
      fromVec(32'h1FFE, 21, pkt0);
      n = encode(pkt0, 1'b1, oq);
      pushExpected(oq);
      applyStimulus(1'b1, 1'b0, 2, 200, seen);
      expCnt = 0;
      checkOutput("post_rst_stuff_cnt", 32'(stuffCnt), 32'(expCnt));
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_out_valid", 32'(ifc.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/bit_stuff_encoder.md
# bit_stuff_encoder

Parametrised bit-stuffing encoder for the USB transmit path. It sits between the CRC5/CRC16 generators (and any further serial sources) and the NRZI encoder. It arbitrates between NUM_SRC serial bit sources and locks onto one source per packet. The first SKIP_LEN bits of each packet pass through unstuffed; after that, a 0 is inserted after every RUN_LEN consecutive ones, including a run that ends on the packet's final bit. It also keeps a saturating count of inserted stuff bits.

## Interface
- RUN_LEN, 6: consecutive ones that trigger one stuff bit; must be ≥1.
- SKIP_LEN, 8: leading bits per packet that are neither stuffed nor counted (PID); 0 allowed.
- NUM_SRC, 2: number of input bit sources; must be ≥1.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source bit valid; a source holds it high contiguously for the whole packet, and deassertion ends the packet.
- src_bit  in  NUM_SRC  per-source serial data bit.
- src_ready  out  NUM_SRC  per-source ready; only the selected/locked source's bit can be high.
- stuff_en  in  1  1 = stuffing active; 0 = pure pass-through (skip/run counting still tracked).
- stat_clr  in  1  synchronous clear of stuff_cnt.
- out_valid  out  1  out_bit is a valid line bit this cycle.
- out_bit  out  1  serial output bit.
- busy  out  1  a packet is in progress (replaces bs_sending).
- stuff_cnt  out  16  saturating count of inserted stuff bits.

## Operation
- Internal state: sel_q (locked source), skip_cnt (0..SKIP_LEN), ones_cnt (0..RUN_LEN-1), FSM {IDLE, SKIP, RUN, STUFF}.
- Transfer: a bit is accepted when the locked source has src_valid=1 and src_ready=1. An accepted bit is driven combinationally: out_bit=src_bit[sel], out_valid=1, same cycle.
- IDLE
  - src_ready asserted to the lowest-index source with valid set.
  - When any valid is set: lock sel_q to that source and accept its bit. skip_cnt becomes 1.
  - Next state is SKIP if SKIP_LEN>1. If SKIP_LEN==1, go to RUN.
  - If SKIP_LEN==0, the first bit goes through RUN rules this same cycle, including possible entry to STUFF when RUN_LEN==1.
- SKIP
  - Accept bits. When skip_cnt reaches SKIP_LEN, go to RUN.
  - ones_cnt held at 0.
- RUN, on each accepted bit:
  - bit=0: ones_cnt←0.
  - bit=1 and ones_cnt+1<RUN_LEN: ones_cnt increments.
  - bit=1 and ones_cnt+1==RUN_LEN:
    - ones_cnt←0.
    - Next state STUFF if stuff_en=1; otherwise stay in RUN.
- STUFF
  - Drive out_valid=1, out_bit=0, all src_ready=0. The source holds its pending bit.
  - stuff_cnt increments.
  - Next state RUN if the locked valid=1, otherwise IDLE. A run ending on the last packet bit therefore still gets its stuff bit (tail stuff).
- Packet end: in SKIP or RUN, locked valid=0 → out_valid=0, go to IDLE. No bit is accepted that cycle, even if another source is valid.
- Other sources' valids are ignored while a packet is locked.
- stuff_en is sampled on the bit that completes a run. Changing it mid-packet affects only later runs.
- stuff_cnt:
  - Holds at 16'hFFFF once saturated.
  - stat_clr has priority over a simultaneous increment; the result is 0.
- busy is 1 in SKIP, RUN and STUFF, and in the IDLE cycle that accepts a first bit.

## Timing
- Reset (asynchronous, immediate):
  - FSM=IDLE; sel_q, skip_cnt, ones_cnt, stuff_cnt = 0.
  - out_valid=0, out_bit=0, busy=0, src_ready=0 unless a src_valid is already high.
- Latency: zero cycles, data in to out_bit.
- Each stuff bit costs exactly one cycle with src_ready=0.
- A packet of N bits with S stuff bits occupies N+S consecutive out_valid cycles. This is followed by at least one IDLE cycle with out_valid=0 before the next packet starts.
- If reset is asserted mid-packet or during STUFF, the packet is dropped; there is no partial stuff bit after release.

## Test plan
- Reset mid-operation: reset_n low during STUFF → out_valid=0 and busy=0 in the same cycle. After release, stuff_cnt=0 and FSM is IDLE.
- PID skip: src0 sends 8 ones then data 1111111 → output is 8 ones, then 111111, 0, 1; stuff_cnt=1. Exactly one src_ready=0 cycle, on the cycle after the sixth data one.
- Tail stuff: PID 8'h00, then six ones, then valid drops → output is 8 zeros, 6 ones, 0 (15 out_valid cycles), then out_valid=0. stuff_cnt=1.
- Arbitration/lock:
  - src1 starts alone; src0 asserts mid-packet → src0 ignored and src_ready[0]=0.
  - When src1 drops, there is one idle cycle, then src0's packet starts.
  - With both valid at once from IDLE, src0 wins.
- Mode: stuff_en=0, PID 8'h00 then 12 ones → 20 output bits with no zeros inserted; stuff_cnt unchanged.
- Saturation: preload via 65535 stuffs (or force), one more stuff → stuff_cnt stays 16'hFFFF. stat_clr in the same cycle as a stuff → 0.
